// File: rtl/prime_gen_pkg.sv
// prime_gen_pkg: shared types and constants for the prime generator.
// Optional macro PRIME_SKIP_EVEN_EN: odd-only candidates and divisors.
package prime_gen_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    REM,
    EMIT,
    FIN
  } state_t;

`ifdef PRIME_SKIP_EVEN_EN
  localparam int CAND_STEP = 2;
  localparam int DIV_INIT  = 3;
  localparam int DIV_STEP  = 2;
  localparam int SQ_INIT   = 9;
  localparam int SQ_MUL    = 4;
  localparam int SQ_ADD    = 4;
`else
  localparam int CAND_STEP = 1;
  localparam int DIV_INIT  = 2;
  localparam int DIV_STEP  = 1;
  localparam int SQ_INIT   = 4;
  localparam int SQ_MUL    = 2;
  localparam int SQ_ADD    = 1;
`endif

endpackage

// File: rtl/prime_generator_divider.sv
// trial_divider: remainder = dividend mod divisor by repeated subtraction.
// Ports: clk, rst, start (pulse), dividend, divisor, remainder, done (pulse).
module trial_divider
  import prime_gen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] remainder,
  output logic         done
);

  logic         run;
  logic [W-1:0] den;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      den       <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= dividend;
        den       <= divisor;
        run       <= 1'b1;
      end else if (run) begin
        if (remainder >= den) begin
          remainder <= remainder - den;
        end else begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prime_generator.sv
// prime_generator: enumerates primes 2..limit on a valid/ready output.
// Ports: clk, rst, start, limit, prime, prime_valid, prime_ready,
// busy, done, count. Macro PRIME_SKIP_EVEN_EN: odd-only stepping.
module prime_generator
  import prime_gen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] limit,
  output logic [W-1:0] prime,
  output logic         prime_valid,
  input  logic         prime_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] count
);

  state_t         state;
  logic [W-1:0]   lim_r;
  logic [W-1:0]   cand;
  logic [W-1:0]   div;
  logic [2*W-1:0] sq;
  logic           div_start;
  logic           div_done;
  logic [W-1:0]   rem;
  logic [W:0]     step;
  logic [W:0]     next_w;
  logic           last;

  trial_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (cand),
    .divisor   (div),
    .remainder (rem),
    .done      (div_done)
  );

  // 2 is the only even prime; skip mode moves 2 -> 3 then odd only.
  // A W+1 bit sum catches both the limit and the all-ones stop.
  always_comb begin
    step = (W+1)'(CAND_STEP);
    if (cand == W'(2)) step = (W+1)'(1);
    next_w = {1'b0, cand} + step;
    last   = (cand == lim_r) || (next_w > {1'b0, lim_r});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lim_r       <= '0;
      cand        <= '0;
      div         <= '0;
      sq          <= '0;
      div_start   <= 1'b0;
      prime       <= '0;
      prime_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
    end else begin
      div_start <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            lim_r <= limit;
            cand  <= W'(2);
            count <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (cand > lim_r) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            div   <= W'(DIV_INIT);
            sq    <= (2*W)'(SQ_INIT);
            state <= CHECK;
          end
        end
        CHECK: begin
          if (sq > {{W{1'b0}}, cand}) begin
            prime       <= cand;
            prime_valid <= 1'b1;
            state       <= EMIT;
          end else begin
            div_start <= 1'b1;
            state     <= REM;
          end
        end
        REM: begin
          if (div_done) begin
            if (rem == '0) begin
              if (last) begin
                state <= FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                cand  <= next_w[W-1:0];
                state <= LOAD;
              end
            end else begin
              // (d+s)^2 = d^2 + 2*s*d + s^2 with s = DIV_STEP
              div   <= div + W'(DIV_STEP);
              sq    <= sq + (2*W)'(SQ_MUL) * {{W{1'b0}}, div}
                          + (2*W)'(SQ_ADD);
              state <= CHECK;
            end
          end
        end
        EMIT: begin
          if (prime_ready) begin
            prime_valid <= 1'b0;
            count       <= count + W'(1);
            if (last) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cand  <= next_w[W-1:0];
              state <= LOAD;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prime_generator.md
Name: prime_generator

Overview:
- Sequential source of primes: on `start`, enumerates every prime p with 2 <= p <= `limit` in ascending order.
- Primality is tested by trial division: repeated subtraction, with divisors up to floor(sqrt(candidate)).
- Each prime is presented on a valid/ready output; consumers are a display or a checker stage.
- The reverse direction of the 4-bit prime detector: it produces primes instead of classifying them.

Parameters:
- W, 8, candidate/limit/prime width in bits (W >= 3).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- limit  input  W  inclusive upper bound; captured on accepted `start`.
- prime  output  W  current prime; stable while `prime_valid`=1.
- prime_valid  output  1  prime available.
- prime_ready  input  1  consumer accepts; transfer when valid&&ready at a rising clk edge.
- busy  output  1  high from accepted `start` until `done`.
- done  output  1  one-cycle pulse when enumeration ends.
- count  output  W  primes transferred in current run; cleared on accepted `start`.

Behaviour:
- Reset (async, rst=1): state=IDLE; prime=0, prime_valid=0, busy=0, done=0, count=0; internal cand/div/rem/sq=0.
- States: IDLE, LOAD, CHECK, REM, EMIT, FIN.
- IDLE: `start`=1 -> capture `limit` into lim_r; cand=2; count=0; busy=1; -> LOAD. Otherwise stay. `start` in any other state is ignored.
- LOAD: if cand > lim_r -> FIN. Else div=2, sq=4, rem=cand; -> CHECK.
- CHECK:
  - if sq > cand -> EMIT (prime).
  - else rem=cand; -> REM.
- REM: one subtraction per cycle while rem >= div (rem=rem-div).
  - When rem < div: if rem==0 -> composite, go to NEXT step. Else div=div+1, sq=sq+2*div+1 (using old div); -> CHECK.
- NEXT step (inline action, no state):
  - if cand==lim_r or cand==all-ones -> FIN.
  - else cand=cand+1; -> LOAD.
- EMIT: prime=cand, prime_valid=1. Hold prime and valid until prime_ready=1.
  - On transfer: prime_valid=0 in the next cycle, count=count+1, then NEXT step.
  - Same-cycle ready with valid counts exactly once.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle; -> IDLE. count is held until the next start.
- Widths:
  - sq is 2W bits; it never wraps.
  - cand never increments past 2^W-1: the all-ones check precedes the increment.
- limit < 2: LOAD -> FIN directly; no prime_valid; done asserted 2 cycles after start; count=0.
- limit=2: emits 2 only. For cand=2 and 3, sq=4 > cand, so CHECK goes straight to EMIT.
- Backpressure: no internal progress while in EMIT with ready=0.
- Reset mid-operation: everything aborts immediately to reset values; no done pulse.
- Latency: not fixed; data-dependent. Bounded by O(sqrt(cand)*cand) cycles per candidate.

Optional Feature:
- Macro: PRIME_SKIP_EVEN_EN.
- Defined:
  - After emitting 2, candidates step by 2 (3, 5, 7, ...).
  - Divisors start at 3 with sq=9 and step by 2; sq update is sq+4*div+4.
  - The all-ones/limit stop also triggers when cand+2 would exceed lim_r or overflow.
  - Output sequence is identical; cycle count is lower.
- Undefined: behaviour as above; every integer candidate, divisors step by 1.

Decomposition:
- Package prime_gen_pkg:
  - state encoding constants (IDLE, LOAD, CHECK, REM, EMIT, FIN);
  - default W;
  - candidate and divisor step constants, selected by PRIME_SKIP_EVEN_EN.
- One sub-module is natural: trial_divider.
  - Computes rem = cand mod div by repeated subtraction with a start/done handshake.
  - Replaces the REM state in the top-level FSM.
  - Ports: clk, rst, start, dividend[W], divisor[W], remainder[W], done.

Test Plan:
- W=8, limit=13, prime_ready=1 -> primes 2,3,5,7,11,13 in order; count=6; one done pulse; busy low after.
- limit=1 (and limit=0) -> prime_valid never asserted; done pulses 2 cycles after start; count=0.
- limit=13, prime_ready held 0 for 5 cycles at the first prime -> prime=2 and valid stable all 5 cycles; single transfer; sequence unchanged.
- limit=255 -> 54 primes, last 251; cand stops at 255 with no wrap; done once. Repeat with PRIME_SKIP_EVEN_EN: same sequence, fewer cycles.
- start pulsed again while busy, limit changed to 50 -> ignored; run completes to the original limit of 13.
- rst asserted mid-REM on cand=9 -> outputs return to reset values asynchronously; no done. A new start with limit=5 yields 2,3,5.
